uart_ctrl: RTL and testbench

//  Register-mapped UART controller. Sits between the SoC MMIO bus and the 8n1 UART PHY.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_fifo.sv | 45 ++++
 rtl/uart_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Register map, STATUS bit positions and address decode shared by the UART controller.
package uart_pkg;

  localparam logic [3:0] UART_REG_DATA   = 4'h0;
  localparam logic [3:0] UART_REG_STATUS = 4'h4;
  localparam logic [3:0] UART_REG_IRQ_EN = 4'h8;

  localparam int unsigned STAT_RX_AVAIL   = 0;
  localparam int unsigned STAT_TX_FULL    = 1;
  localparam int unsigned STAT_TX_IDLE    = 2;
  localparam int unsigned STAT_RX_OVERRUN = 3;

  typedef enum logic [1:0] {
    RegData,
    RegStatus,
    RegIrqEn,
    RegNone
  } uart_reg_e;

  // Offsets are word aligned; only the word index takes part in the decode.
  function automatic uart_reg_e uart_decode(logic [1:0] word);
    if (word == UART_REG_DATA[3:2]) return RegData;
    if (word == UART_REG_STATUS[3:2]) return RegStatus;
    if (word == UART_REG_IRQ_EN[3:2]) return RegIrqEn;
    return RegNone;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as 0 while empty.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push is accepted even when full.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_ctrl.sv
// Register-mapped UART controller: TX/RX FIFOs between the MMIO bus and the 8n1 PHY.
// Define UART_CTRL_IRQ_EN to add the IRQ_EN register and a registered irq output.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_bus_valid,
  input  logic       i_bus_we,
  input  logic [3:0] i_bus_addr,
  input  logic [7:0] i_bus_wdata,
  output logic       o_bus_rvalid,
  output logic [7:0] o_bus_rdata,
  output logic [7:0] o_phy_tx_data,
  output logic       o_phy_tx_valid,
  input  logic       i_phy_tx_ready,
  input  logic [7:0] i_phy_rx_data,
  input  logic       i_phy_rx_ready,
  output logic       o_irq
);

  uart_reg_e  w_reg;
  logic       w_rd;
  logic       w_wr;
  logic       w_unused_addr;
  logic       w_tx_push;
  logic       w_tx_pop;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_tx_idle;
  logic       w_rx_pop;
  logic       w_rx_edge;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic [7:0] w_rx_head;
  logic [7:0] w_status;
  logic [7:0] w_rdata_d;
  logic       r_rx_prev;
  logic       r_overrun;
  logic       r_rvalid;
  logic [7:0] r_rdata;

  assign w_reg         = uart_decode(i_bus_addr[3:2]);
  assign w_unused_addr = ^i_bus_addr[1:0];
  assign w_rd          = i_bus_valid && !i_bus_we;
  assign w_wr          = i_bus_valid && i_bus_we;

  assign w_tx_push      = w_wr && (w_reg == RegData);
  assign w_tx_pop       = !w_tx_empty && i_phy_tx_ready;
  assign w_tx_idle      = w_tx_empty && i_phy_tx_ready;
  assign o_phy_tx_valid = !w_tx_empty;

  uart_fifo #(
    .WIDTH(8),
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_tx_push),
    .i_wdata(i_bus_wdata),
    .i_pop  (w_tx_pop),
    .o_rdata(o_phy_tx_data),
    .o_full (w_tx_full),
    .o_empty(w_tx_empty)
  );

  // Only the rising edge of the level strobe is a new byte.
  assign w_rx_edge = i_phy_rx_ready && !r_rx_prev;
  assign w_rx_pop  = w_rd && (w_reg == RegData);

  uart_fifo #(
    .WIDTH(8),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_rx_edge),
    .i_wdata(i_phy_rx_data),
    .i_pop  (w_rx_pop),
    .o_rdata(w_rx_head),
    .o_full (w_rx_full),
    .o_empty(w_rx_empty)
  );

  always_comb begin
    w_status                  = '0;
    w_status[STAT_RX_AVAIL]   = !w_rx_empty;
    w_status[STAT_TX_FULL]    = w_tx_full;
    w_status[STAT_TX_IDLE]    = w_tx_idle;
    w_status[STAT_RX_OVERRUN] = r_overrun;
  end

`ifdef UART_CTRL_IRQ_EN
  logic [1:0] r_irq_en;
  logic       r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_reg == RegIrqEn)) r_irq_en <= i_bus_wdata[1:0];
      r_irq <= (r_irq_en[0] && !w_rx_empty) || (r_irq_en[1] && w_tx_idle) || r_overrun;
    end
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

  always_comb begin
    w_rdata_d = '0;
    if (w_rd) begin
      unique case (w_reg)
        RegData:   w_rdata_d = w_rx_head;
        RegStatus: w_rdata_d = w_status;
`ifdef UART_CTRL_IRQ_EN
        RegIrqEn:  w_rdata_d = {6'b0, r_irq_en};
`endif
        default:   w_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_prev <= 1'b0;
      r_overrun <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rx_prev <= i_phy_rx_ready;
      r_rvalid  <= w_rd;
      r_rdata   <= w_rdata_d;
      // A byte arriving while full is lost unless a DATA read frees a slot; set beats clear.
      if (w_rx_edge && w_rx_full && !w_rx_pop) r_overrun <= 1'b1;
      else if (w_rd && (w_reg == RegStatus))  r_overrun <= 1'b0;
    end
  end

  assign o_bus_rvalid = r_rvalid;
  assign o_bus_rdata  = r_rdata;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: directed scenarios plus a randomized run against a queue model.
module tb_uart_ctrl;
  import uart_pkg::*;

  localparam int unsigned TXD = 16;
  localparam int unsigned RXD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_valid;
  logic       bus_we;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_rvalid;
  logic [7:0] bus_rdata;
  logic [7:0] phy_tx_data;
  logic       phy_tx_valid;
  logic       phy_tx_ready;
  logic [7:0] phy_rx_data;
  logic       phy_rx_ready;
  logic       irq;

  int total = 0;
  int bad   = 0;
  logic [7:0] seen[$];

  always #5 clk = ~clk;

  uart_ctrl #(
    .TX_DEPTH(TXD),
    .RX_DEPTH(RXD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_bus_valid   (bus_valid),
    .i_bus_we      (bus_we),
    .i_bus_addr    (bus_addr),
    .i_bus_wdata   (bus_wdata),
    .o_bus_rvalid  (bus_rvalid),
    .o_bus_rdata   (bus_rdata),
    .o_phy_tx_data (phy_tx_data),
    .o_phy_tx_valid(phy_tx_valid),
    .i_phy_tx_ready(phy_tx_ready),
    .i_phy_rx_data (phy_rx_data),
    .i_phy_rx_ready(phy_rx_ready),
    .o_irq         (irq)
  );

  always @(negedge clk) begin
    if (!rst && phy_tx_valid && phy_tx_ready) seen.push_back(phy_tx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic rv, output logic [7:0] d);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a;
    tick();
    bus_valid = 1'b0;
    rv = bus_rvalid;
    d  = bus_rdata;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    phy_rx_data = d; phy_rx_ready = 1'b1;
    tick();
    phy_rx_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic rv; logic [7:0] d;
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({bus_rvalid, bus_rdata, phy_tx_valid, phy_tx_data, irq} !== 19'h0) begin
      bad++;
      $display("FAIL reset_outputs: got rv=%0b rd=%02h txv=%0b txd=%02h irq=%0b want all 0",
               bus_rvalid, bus_rdata, phy_tx_valid, phy_tx_data, irq);
    end
    rst = 1'b0;
    tick();
    bus_read(UART_REG_STATUS, rv, d);
    total++;
    if (rv !== 1'b1 || d !== 8'h00) begin
      bad++; $display("FAIL reset_status: got rv=%0b %02h want rv=1 00", rv, d);
    end
    phy_tx_ready = 1'b1;
    bus_read(UART_REG_STATUS, rv, d);
    total++;
    if (d !== 8'h04) begin bad++; $display("FAIL reset_status_idle: got %02h want 04", d); end
  endtask

  task automatic test_tx_basic();
    logic rv; logic [7:0] d;
    seen.delete();
    phy_tx_ready = 1'b1;
    bus_write(UART_REG_DATA, 8'h55);
    total++;
    if (phy_tx_valid !== 1'b1 || phy_tx_data !== 8'h55) begin
      bad++; $display("FAIL tx_latency: got v=%0b %02h want v=1 55", phy_tx_valid, phy_tx_data);
    end
    bus_write(UART_REG_DATA, 8'hAA);
    repeat (3) tick();
    total++;
    if (seen.size() != 2) begin
      bad++; $display("FAIL tx_basic_count: got %0d want 2", seen.size());
    end else if (seen[0] !== 8'h55 || seen[1] !== 8'hAA) begin
      bad++; $display("FAIL tx_basic_order: got %02h %02h want 55 aa", seen[0], seen[1]);
    end
    bus_read(UART_REG_STATUS, rv, d);
    total++;
    if (d !== 8'h04) begin bad++; $display("FAIL tx_basic_idle: got %02h want 04", d); end
  endtask

  task automatic test_tx_full();
    logic rv; logic [7:0] d; logic [7:0] b;
    logic [7:0] exp[$];
    phy_tx_ready = 1'b0;
    seen.delete();
    for (int i = 0; i < TXD + 1; i++) begin
      b = 8'($urandom);
      bus_write(UART_REG_DATA, b);
      if (i < TXD) exp.push_back(b);
    end
    bus_read(UART_REG_STATUS, rv, d);
    total++;
    if (d !== 8'h02) begin bad++; $display("FAIL tx_full_status: got %02h want 02", d); end
    phy_tx_ready = 1'b1;
    repeat (TXD + 4) tick();
    phy_tx_ready = 1'b0;
    total++;
    if (seen.size() != TXD) begin
      bad++; $display("FAIL tx_full_count: got %0d want %0d", seen.size(), TXD);
    end else begin
      for (int i = 0; i < TXD; i++) begin
        total++;
        if (seen[i] !== exp[i]) begin
          bad++; $display("FAIL tx_full_byte%0d: got %02h want %02h", i, seen[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_rx_single();
    logic rv; logic [7:0] d;
    phy_rx_data = 8'h3C; phy_rx_ready = 1'b1;
    repeat (3) tick();
    phy_rx_ready = 1'b0;
    tick();
    bus_read(UART_REG_DATA, rv, d);
    total++;
    if (rv !== 1'b1 || d !== 8'h3C) begin
      bad++; $display("FAIL rx_single_data: got rv=%0b %02h want rv=1 3c", rv, d);
    end
    bus_read(UART_REG_DATA, rv, d);
    total++;
    if (rv !== 1'b1 || d !== 8'h00) begin
      bad++; $display("FAIL rx_single_empty: got rv=%0b %02h want rv=1 00", rv, d);
    end
  endtask

  task automatic test_rx_overrun();
    logic rv; logic [7:0] d; logic [7:0] b;
    logic [7:0] exp[$];
    phy_tx_ready = 1'b0;
    for (int i = 0; i < RXD + 1; i++) begin
      b = 8'($urandom);
      rx_pulse(b);
      if (i < RXD) exp.push_back(b);
    end
    bus_read(UART_REG_STATUS, rv, d);
    total++;
    if (d !== 8'h09) begin bad++; $display("FAIL overrun_status: got %02h want 09", d); end
    bus_read(UART_REG_STATUS, rv, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL overrun_clear: got %02h want 01", d); end
    for (int i = 0; i < RXD; i++) begin
      bus_read(UART_REG_DATA, rv, d);
      total++;
      if (d !== exp[i]) begin
        bad++; $display("FAIL overrun_byte%0d: got %02h want %02h", i, d, exp[i]);
      end
    end
    bus_read(UART_REG_STATUS, rv, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL overrun_drained: got %02h want 00", d); end
  endtask

  task automatic test_rx_collision();
    logic rv; logic [7:0] d; logic [7:0] b;
    logic [7:0] exp[$];
    for (int i = 0; i < RXD; i++) begin
      b = 8'($urandom);
      rx_pulse(b);
      exp.push_back(b);
    end
    b = 8'($urandom);
    phy_rx_data = b; phy_rx_ready = 1'b1;
    bus_read(UART_REG_DATA, rv, d);
    phy_rx_ready = 1'b0;
    total++;
    if (d !== exp[0]) begin bad++; $display("FAIL collide_head: got %02h want %02h", d, exp[0]); end
    d = exp.pop_front();
    exp.push_back(b);
    bus_read(UART_REG_STATUS, rv, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL collide_status: got %02h want 01", d); end
    for (int i = 0; i < RXD; i++) begin
      bus_read(UART_REG_DATA, rv, d);
      total++;
      if (d !== exp[i]) begin
        bad++; $display("FAIL collide_byte%0d: got %02h want %02h", i, d, exp[i]);
      end
    end
    bus_read(UART_REG_DATA, rv, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL collide_empty: got %02h want 00", d); end
  endtask

  task automatic test_unmapped();
    logic rv; logic [7:0] d;
    phy_tx_ready = 1'b0;
    bus_write(UART_REG_IRQ_EN, 8'h03);
    bus_write(4'hC, 8'h77);
    bus_write(UART_REG_STATUS, 8'h99);
    tick();
    total++;
    if (phy_tx_valid !== 1'b0) begin
      bad++; $display("FAIL unmapped_write: got txv=%0b want 0", phy_tx_valid);
    end
    bus_read(4'hC, rv, d);
    total++;
    if (rv !== 1'b1 || d !== 8'h00) begin
      bad++; $display("FAIL unmapped_read: got rv=%0b %02h want rv=1 00", rv, d);
    end
    bus_read(UART_REG_IRQ_EN, rv, d);
    total++;
`ifdef UART_CTRL_IRQ_EN
    if (d !== 8'h03) begin bad++; $display("FAIL irq_en_read: got %02h want 03", d); end
`else
    if (d !== 8'h00) begin bad++; $display("FAIL irq_en_absent: got %02h want 00", d); end
`endif
    bus_write(UART_REG_IRQ_EN, 8'h00);
  endtask

  task automatic test_irq();
    logic rv; logic [7:0] d;
    phy_tx_ready = 1'b0;
`ifdef UART_CTRL_IRQ_EN
    bus_write(UART_REG_IRQ_EN, 8'h01);
    tick();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_quiet: got %0b want 0", irq); end
    rx_pulse(8'h5A);
    tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx: got %0b want 1", irq); end
    bus_read(UART_REG_DATA, rv, d);
    tick(); tick();
    total++;
    if (irq !== 1'b0 || d !== 8'h5A) begin
      bad++; $display("FAIL irq_drain: got irq=%0b %02h want irq=0 5a", irq, d);
    end
    bus_write(UART_REG_IRQ_EN, 8'h00);
`else
    bus_write(UART_REG_IRQ_EN, 8'h03);
    rx_pulse(8'h5A);
    tick();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_tied: got %0b want 0", irq); end
    bus_read(UART_REG_DATA, rv, d);
    total++;
    if (d !== 8'h5A) begin bad++; $display("FAIL irq_rx_data: got %02h want 5a", d); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] mtx[$];
    logic [7:0] mrx[$];
    logic [7:0] junk;
    logic       movr, mprev, exp_rv, exp_irq;
    logic [7:0] exp_rd;
    logic [1:0] men;
    rst = 1'b1; bus_valid = 1'b0; bus_we = 1'b0; phy_rx_ready = 1'b0; phy_tx_ready = 1'b0;
    tick();
    rst = 1'b0;
    movr = 1'b0; mprev = 1'b0; exp_rv = 1'b0; exp_rd = 8'h00; exp_irq = 1'b0; men = 2'b00;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic [1:0] word;
      logic       rd, wr, txr, rxr;
      logic [7:0] wd, rxd;
      int unsigned op;
      total++;
      if (phy_tx_valid !== (mtx.size() != 0)) begin
        bad++; $display("FAIL rand_txv c%0d: got %0b want %0b", cyc, phy_tx_valid, mtx.size() != 0);
      end
      if (mtx.size() != 0) begin
        total++;
        if (phy_tx_data !== mtx[0]) begin
          bad++; $display("FAIL rand_txd c%0d: got %02h want %02h", cyc, phy_tx_data, mtx[0]);
        end
      end
      total++;
      if (bus_rvalid !== exp_rv || bus_rdata !== exp_rd) begin
        bad++;
        $display("FAIL rand_read c%0d: got rv=%0b %02h want rv=%0b %02h",
                 cyc, bus_rvalid, bus_rdata, exp_rv, exp_rd);
      end
      total++;
      if (irq !== exp_irq) begin
        bad++; $display("FAIL rand_irq c%0d: got %0b want %0b", cyc, irq, exp_irq);
      end

      op = $urandom_range(0, 9);
      word = 2'd0; rd = 1'b0; wr = 1'b0;
      case (op)
        0, 1, 2: wr = 1'b1;
        3, 4:    rd = 1'b1;
        5:       begin rd = 1'b1; word = 2'd1; end
        6:       begin word = 2'($urandom_range(1, 3)); wr = 1'($urandom_range(0, 1)); rd = !wr; end
        default: ;
      endcase
      wd  = 8'($urandom);
      rxd = 8'($urandom);
      txr = (cyc % 200 < 100) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      rxr = (cyc % 200 < 100) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      bus_valid = rd || wr; bus_we = wr; bus_addr = {word, 2'($urandom)}; bus_wdata = wd;
      phy_tx_ready = txr; phy_rx_ready = rxr; phy_rx_data = rxd;

      exp_rv = rd;
      exp_rd = 8'h00;
      if (rd) begin
        if (word == 2'd0 && mrx.size() != 0) exp_rd = mrx[0];
        else if (word == 2'd1)
          exp_rd = {4'h0, movr, (mtx.size() == 0) && txr, mtx.size() == TXD, mrx.size() != 0};
`ifdef UART_CTRL_IRQ_EN
        else if (word == 2'd2) exp_rd = {6'h0, men};
`endif
      end
`ifdef UART_CTRL_IRQ_EN
      exp_irq = (men[0] && mrx.size() != 0) || (men[1] && mtx.size() == 0 && txr) || movr;
      if (wr && word == 2'd2) men = wd[1:0];
`endif
      if (mtx.size() != 0 && txr) junk = mtx.pop_front();
      if (wr && word == 2'd0 && mtx.size() < TXD) mtx.push_back(wd);
      if (rd && word == 2'd1) movr = 1'b0;
      if (rd && word == 2'd0 && mrx.size() != 0) junk = mrx.pop_front();
      if (rxr && !mprev) begin
        if (mrx.size() < RXD) mrx.push_back(rxd);
        else movr = 1'b1;
      end
      mprev = rxr;
      tick();
    end
    bus_valid = 1'b0; bus_we = 1'b0; phy_rx_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic rv; logic [7:0] d;
    phy_tx_ready = 1'b0;
    bus_write(UART_REG_DATA, 8'hE7);
    rx_pulse(8'h81);
    rst = 1'b1;
    tick();
    total++;
    if ({bus_rvalid, bus_rdata, phy_tx_valid, phy_tx_data, irq} !== 19'h0) begin
      bad++;
      $display("FAIL midrun_reset: got rv=%0b rd=%02h txv=%0b txd=%02h irq=%0b want all 0",
               bus_rvalid, bus_rdata, phy_tx_valid, phy_tx_data, irq);
    end
    rst = 1'b0;
    bus_read(UART_REG_DATA, rv, d);
    total++;
    if (rv !== 1'b1 || d !== 8'h00) begin
      bad++; $display("FAIL midrun_rx_empty: got rv=%0b %02h want rv=1 00", rv, d);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 8'h00;
    phy_tx_ready = 1'b0; phy_rx_data = 8'h00; phy_rx_ready = 1'b0;
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_single();
    test_rx_overrun();
    test_rx_collision();
    test_unmapped();
    test_irq();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
